// File: rtl/ahb_ram_gen2_if.sv
// AHB-Lite slave-side bus bundle for ahb_ram_gen2.
interface ahb_ram_gen2_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  S_HSEL;
   logic [1:0]            S_HTRANS;
   logic                  S_HWRITE;
   logic                  S_HMASTLOCK;
   logic [2:0]            S_HSIZE;
   logic [2:0]            S_HBURST;
   logic [3:0]            S_HPROT;
   logic [31:0]           S_HADDR;
   logic [DATA_WIDTH-1:0] S_HWDATA;
   logic                  S_HREADY;
   logic                  S_HREADYOUT;
   logic [DATA_WIDTH-1:0] S_HRDATA;
   logic                  S_HRESP;

   modport master (
      output S_HSEL, S_HTRANS, S_HWRITE, S_HMASTLOCK, S_HSIZE, S_HBURST,
             S_HPROT, S_HADDR, S_HWDATA, S_HREADY,
      input  S_HREADYOUT, S_HRDATA, S_HRESP
   );

   modport slave (
      input  S_HSEL, S_HTRANS, S_HWRITE, S_HMASTLOCK, S_HSIZE, S_HBURST,
             S_HPROT, S_HADDR, S_HWDATA, S_HREADY,
      output S_HREADYOUT, S_HRDATA, S_HRESP
   );
endinterface

// File: rtl/ahb_ram_gen2.sv
// AHB-Lite RAM slave: byte-lane strobes, fixed wait states, write-to-read forwarding.
// Define AHB_RAM_GEN2_ERR_EN to answer oversize/misaligned transfers with a two-cycle ERROR.
module ahb_ram_gen2 #(
   parameter int RAM_SIZE    = 32768,
   parameter int DATA_WIDTH  = 32,
   parameter int WAIT_CYCLES = 0
) (
   input  logic            CLK,
   input  logic            RES_N,
   ahb_ram_gen2_if.slave   bus
);
   localparam int NLANE    = DATA_WIDTH / 8;
   localparam int LSB      = $clog2(NLANE);
   localparam int RAM_ADDR = $clog2(RAM_SIZE);
   localparam int DEPTH    = RAM_SIZE / NLANE;
   localparam int WA       = RAM_ADDR - LSB;
   localparam logic [3:0] WC = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;

   state_t                state_q;
   logic [3:0]            cnt_q;
   logic                  hready_q;
   logic                  hresp_q;
   logic                  dphase_q;
   logic                  wr_q;
   logic [WA-1:0]         wa_q;
   logic [NLANE-1:0]      mask_q;
   logic [DATA_WIDTH-1:0] rdata_q;

   logic [7:0] mem [NLANE][DEPTH];

   logic                  accept, commit, illegal, oversize;
   logic [2:0]            sz;
   logic [LSB-1:0]        lo;
   logic [WA-1:0]         wa_d;
   logic [NLANE-1:0]      mask_d;
   logic [DATA_WIDTH-1:0] rdata_d;
`ifdef AHB_RAM_GEN2_ERR_EN
   logic                  misalign;
`endif

   assign accept = bus.S_HSEL & bus.S_HREADY & bus.S_HTRANS[1];
   assign commit = dphase_q & hready_q & wr_q;

   always_comb begin
      lo       = bus.S_HADDR[LSB-1:0];
      wa_d     = bus.S_HADDR[RAM_ADDR-1:LSB];
      oversize = bus.S_HSIZE > 3'(LSB);
      sz       = oversize ? 3'(LSB) : bus.S_HSIZE;
      mask_d   = '0;
      rdata_d  = '0;
      // A lane is enabled when it sits in the same size-aligned block as the address.
      for (int i = 0; i < NLANE; i++) begin
         mask_d[i] = (i >> sz) == (int'(lo) >> sz);
         rdata_d[8*i +: 8] = (commit && wa_q == wa_d && mask_q[i]) ?
                             bus.S_HWDATA[8*i +: 8] : mem[i][wa_d];
      end
`ifdef AHB_RAM_GEN2_ERR_EN
      misalign = (int'(lo) & ((1 << sz) - 1)) != 0;
      illegal  = oversize | misalign;
`else
      illegal  = 1'b0;
`endif
   end

   always_ff @(posedge CLK) begin
      if (RES_N && commit) begin
         for (int i = 0; i < NLANE; i++) begin
            if (mask_q[i]) mem[i][wa_q] <= bus.S_HWDATA[8*i +: 8];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RES_N) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         hready_q <= 1'b1;
         hresp_q  <= 1'b0;
         dphase_q <= 1'b0;
         wr_q     <= 1'b0;
         wa_q     <= '0;
         mask_q   <= '0;
         rdata_q  <= '0;
      end else if (hready_q) begin
         // Bus may advance: close any data phase and take the next address phase.
         state_q  <= IDLE;
         hresp_q  <= 1'b0;
         dphase_q <= 1'b0;
         if (accept) begin
            if (illegal) begin
               state_q  <= ERR1;
               hready_q <= 1'b0;
               hresp_q  <= 1'b1;
            end else begin
               dphase_q <= 1'b1;
               wr_q     <= bus.S_HWRITE;
               wa_q     <= wa_d;
               mask_q   <= mask_d;
               cnt_q    <= '0;
               if (!bus.S_HWRITE) rdata_q <= rdata_d;
               if (WC != 4'd0) begin
                  state_q  <= WAIT;
                  hready_q <= 1'b0;
               end
            end
         end
      end else begin
         case (state_q)
            ERR1: begin
               state_q  <= ERR2;
               hready_q <= 1'b1;
            end
            WAIT: begin
               cnt_q    <= cnt_q + 4'd1;
               hready_q <= (cnt_q + 4'd1) == WC;
            end
            default: hready_q <= 1'b1;
         endcase
      end
   end

   assign bus.S_HREADYOUT = hready_q;
   assign bus.S_HRDATA    = (dphase_q & hready_q & ~wr_q) ? rdata_q : '0;

   logic unused_ok;
`ifdef AHB_RAM_GEN2_ERR_EN
   assign bus.S_HRESP = hresp_q;
   assign unused_ok   = ^{bus.S_HMASTLOCK, bus.S_HBURST, bus.S_HPROT,
                          bus.S_HTRANS[0], bus.S_HADDR[31:RAM_ADDR]};
`else
   assign bus.S_HRESP = 1'b0;
   assign unused_ok   = ^{bus.S_HMASTLOCK, bus.S_HBURST, bus.S_HPROT,
                          bus.S_HTRANS[0], bus.S_HADDR[31:RAM_ADDR], hresp_q};
`endif
endmodule

// File: tb/tb_ahb_ram_gen2.sv
// Bench for ahb_ram_gen2: three instances (32b/0ws, 64b/0ws, 32b/3ws) on one shared driver.
module tb_ahb_ram_gen2;
`ifdef AHB_RAM_GEN2_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif
   localparam int NL [3] = '{4, 8, 4};
   localparam int WS [3] = '{0, 0, 3};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  cur = 2'd0;
   logic [1:0]  htrans = 2'b00;
   logic        hwrite = 1'b0;
   logic [2:0]  hsize = 3'd0;
   logic [31:0] haddr = 32'h0;
   logic [63:0] hwdata = 64'h0;

   logic        cur_ready, cur_resp;
   logic [63:0] cur_rdata;

   int n_err = 0;
   int n_chk = 0;
   logic [63:0] sb [$];

   bit          pend_vld = 1'b0;
   bit          pend_rd  = 1'b0;
   bit          pend_err = 1'b0;

   always #5 clk = ~clk;

   ahb_ram_gen2_if #(.DATA_WIDTH(32)) b0 ();
   ahb_ram_gen2_if #(.DATA_WIDTH(64)) b1 ();
   ahb_ram_gen2_if #(.DATA_WIDTH(32)) b2 ();

   assign b0.S_HSEL = (cur == 2'd0);
   assign b1.S_HSEL = (cur == 2'd1);
   assign b2.S_HSEL = (cur == 2'd2);
   assign b0.S_HREADY = b0.S_HREADYOUT;
   assign b1.S_HREADY = b1.S_HREADYOUT;
   assign b2.S_HREADY = b2.S_HREADYOUT;
   assign b0.S_HWDATA = hwdata[31:0];
   assign b1.S_HWDATA = hwdata;
   assign b2.S_HWDATA = hwdata[31:0];
   assign {b0.S_HTRANS, b0.S_HWRITE, b0.S_HSIZE, b0.S_HADDR} = {htrans, hwrite, hsize, haddr};
   assign {b1.S_HTRANS, b1.S_HWRITE, b1.S_HSIZE, b1.S_HADDR} = {htrans, hwrite, hsize, haddr};
   assign {b2.S_HTRANS, b2.S_HWRITE, b2.S_HSIZE, b2.S_HADDR} = {htrans, hwrite, hsize, haddr};
   assign {b0.S_HMASTLOCK, b0.S_HBURST, b0.S_HPROT} = {1'b0, 3'b000, 4'h3};
   assign {b1.S_HMASTLOCK, b1.S_HBURST, b1.S_HPROT} = {1'b0, 3'b000, 4'h3};
   assign {b2.S_HMASTLOCK, b2.S_HBURST, b2.S_HPROT} = {1'b0, 3'b000, 4'h3};

   ahb_ram_gen2 #(.RAM_SIZE(32768), .DATA_WIDTH(32), .WAIT_CYCLES(0)) dut0 (.CLK(clk), .RES_N(rst_n), .bus(b0));
   ahb_ram_gen2 #(.RAM_SIZE(32768), .DATA_WIDTH(64), .WAIT_CYCLES(0)) dut1 (.CLK(clk), .RES_N(rst_n), .bus(b1));
   ahb_ram_gen2 #(.RAM_SIZE(32768), .DATA_WIDTH(32), .WAIT_CYCLES(3)) dut2 (.CLK(clk), .RES_N(rst_n), .bus(b2));

   always_comb begin
      cur_ready = 1'b1;
      cur_resp  = 1'b0;
      cur_rdata = 64'h0;
      case (cur)
         2'd0: begin cur_ready = b0.S_HREADYOUT; cur_resp = b0.S_HRESP; cur_rdata = {32'h0, b0.S_HRDATA}; end
         2'd1: begin cur_ready = b1.S_HREADYOUT; cur_resp = b1.S_HRESP; cur_rdata = b1.S_HRDATA; end
         2'd2: begin cur_ready = b2.S_HREADYOUT; cur_resp = b2.S_HRESP; cur_rdata = {32'h0, b2.S_HRDATA}; end
         default: ;
      endcase
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s (dut%0d): got %h expected %h", tag, cur, got, exp);
      end
   endtask

   function automatic bit illegal_f(input logic [31:0] a, input logic [2:0] sz);
      int lsb = (NL[cur] == 8) ? 3 : 2;
      bit ov  = int'(sz) > lsb;
      bit mis = (int'(a[2:0]) & ((1 << sz) - 1)) != 0;
      return ERR_EN && (ov || mis);
   endfunction

   // Present one address phase (or idle) until accepted, retiring the previous data phase.
   task automatic step(input bit nt, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                       input logic [63:0] wd, input bit err);
      int waits = 0;
      @(negedge clk);
      if (nt) begin
         htrans = 2'b10; hwrite = wr; haddr = a; hsize = sz;
      end else begin
         htrans = 2'b00;
      end
      while (!cur_ready) begin
         if (pend_vld) begin
            chk("resp_wait", {63'h0, cur_resp}, {63'h0, pend_err});
            if (pend_rd) chk("rdata_wait", cur_rdata, 64'h0);
         end
         waits++;
         if (waits > 40) begin
            chk("ready_timeout", {63'h0, cur_ready}, 64'h1);
            break;
         end
         @(negedge clk);
      end
      if (pend_vld) begin
         chk("wait_count", 64'(waits), 64'(pend_err ? 1 : WS[cur]));
         chk("resp", {63'h0, cur_resp}, {63'h0, pend_err});
         if (pend_rd && !pend_err) begin
            if (sb.size() == 0) chk("sb_size", 64'(sb.size()), 64'h1);
            else chk("rdata", cur_rdata, sb.pop_front());
         end else begin
            chk("rdata_idle", cur_rdata, 64'h0);
         end
      end
      @(posedge clk);
      #1;
      pend_vld = nt;
      pend_rd  = nt & ~wr;
      pend_err = err;
      hwdata   = wd;
      htrans   = 2'b00;
   endtask

   task automatic wr_op(input logic [31:0] a, input logic [2:0] sz, input logic [63:0] wd);
      step(1'b1, 1'b1, a, sz, wd, illegal_f(a, sz));
   endtask

   task automatic rd_op(input logic [31:0] a, input logic [2:0] sz, input logic [63:0] exp);
      bit err = illegal_f(a, sz);
      if (!err) sb.push_back(exp);
      step(1'b1, 1'b0, a, sz, 64'h0, err);
   endtask

   task automatic flush();
      step(1'b0, 1'b0, 32'h0, 3'd0, 64'h0, 1'b0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         cur = 2'(k);
         #1;
         chk("rst_ready", {63'h0, cur_ready}, 64'h1);
         chk("rst_resp", {63'h0, cur_resp}, 64'h0);
         chk("rst_rdata", cur_rdata, 64'h0);
      end
      rst_n = 1'b1;

      // 32-bit, zero wait: forwarding, address wrap, sub-word writes, illegal transfers.
      cur = 2'd0;
      wr_op(32'h100, 3'd2, 64'h11223344);
      rd_op(32'h100, 3'd2, 64'h11223344);
      flush();
      rd_op(32'h8100, 3'd2, 64'h11223344);
      wr_op(32'h104, 3'd2, 64'h5A5A5A5A);
      wr_op(32'h106, 3'd1, 64'hC3C30000);
      rd_op(32'h104, 3'd2, 64'hC3C35A5A);
      wr_op(32'h100, 3'd2, 64'hA5A5A5A5);
      flush();
      wr_op(32'h101, 3'd1, 64'h7777BEEF);
      rd_op(32'h100, 3'd2, ERR_EN ? 64'hA5A5A5A5 : 64'hA5A5BEEF);
      flush();
      wr_op(32'h104, 3'd3, 64'h01020304);
      rd_op(32'h104, 3'd2, ERR_EN ? 64'hC3C35A5A : 64'h01020304);
      rd_op(32'h102, 3'd2, ERR_EN ? 64'h0 : 64'hA5A5BEEF);
      flush();

      // 64-bit lanes, including partial forwarding.
      cur = 2'd1;
      wr_op(32'h100, 3'd3, 64'h0);
      flush();
      wr_op(32'h105, 3'd0, 64'hAB << 40);
      flush();
      rd_op(32'h100, 3'd3, 64'h0000AB0000000000);
      wr_op(32'h108, 3'd3, 64'h0102030405060708);
      wr_op(32'h10A, 3'd0, 64'hCD << 16);
      rd_op(32'h108, 3'd3, 64'h0102030405CD0708);
      wr_op(32'h10C, 3'd2, 64'hFFEEDDCC << 32);
      rd_op(32'h108, 3'd3, 64'hFFEEDDCC05CD0708);
      flush();

      // Three wait states; ERROR stays two cycles regardless.
      cur = 2'd2;
      wr_op(32'h40, 3'd2, 64'hDEADBEEF);
      rd_op(32'h40, 3'd2, 64'hDEADBEEF);
      flush();
      wr_op(32'h42, 3'd2, 64'h0);
      rd_op(32'h40, 3'd2, ERR_EN ? 64'hDEADBEEF : 64'h0);
      flush();

      // Reset during the second wait cycle of a write discards it.
      wr_op(32'h200, 3'd2, 64'hCAFEF00D);
      flush();
      step(1'b1, 1'b1, 32'h200, 3'd2, 64'h12345678, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_ready", {63'h0, cur_ready}, 64'h1);
      chk("midrst_resp", {63'h0, cur_resp}, 64'h0);
      chk("midrst_rdata", cur_rdata, 64'h0);
      rst_n    = 1'b1;
      pend_vld = 1'b0;
      rd_op(32'h200, 3'd2, 64'hCAFEF00D);
      flush();
      chk("sb_drained", 64'(sb.size()), 64'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/ahb_ram_gen2.md
# ahb_ram_gen2

Second-generation AHB-Lite slave RAM with a parametrised data width of 32 or 64 bits, per-byte lane strobes and a programmable fixed wait-state count. It forwards write data to a back-to-back read of the same word, and can optionally return an ERROR response for illegal transfers. It sits on the system AHB matrix as an instruction/data RAM slave, behind the address decoder that drives S_HSEL.

## Interface
- RAM_SIZE, 32768: capacity in bytes; a power of two and ≥ 4×(DATA_WIDTH/8).
- DATA_WIDTH, 32: bus and word width; the legal values are 32 and 64.
- WAIT_CYCLES, 0: wait states inserted in every data phase; range 0..15.
- Derived values: NLANE = DATA_WIDTH/8; LSB = log2(NLANE); RAM_ADDR = log2(RAM_SIZE).

- CLK  in  1  system clock; all logic is rising-edge.
- RES_N  in  1  reset, synchronous, active-low.
- S_HSEL  in  1  slave select.
- S_HTRANS  in  2  transfer type; bit 1 marks NONSEQ/SEQ.
- S_HWRITE  in  1  1 = write.
- S_HMASTLOCK  in  1  ignored.
- S_HSIZE  in  3  transfer size.
- S_HBURST  in  3  ignored.
- S_HPROT  in  4  ignored.
- S_HADDR  in  32  byte address; only bits [RAM_ADDR-1:0] are used, so accesses wrap modulo RAM_SIZE.
- S_HWDATA  in  DATA_WIDTH  write data, valid during the data phase.
- S_HREADY  in  1  bus ready.
- S_HREADYOUT  out  1  slave ready.
- S_HRDATA  out  DATA_WIDTH  read data.
- S_HRESP  out  1  0 = OKAY, 1 = ERROR.

## Operation
- Address phase is accepted when S_HSEL & S_HREADY & S_HTRANS[1]. The block then latches address, write flag, size and byte-enable mask.
- Lane mask:
  - NLANE-bit mask, one bit per byte lane.
  - Size 2^S covers lanes [a, a+2^S) with a = HADDR[LSB-1:0] & ~(2^S−1).
  - An S_HSIZE > LSB is oversize.
  - Misaligned means HADDR[LSB-1:0] is not a multiple of 2^S.
- Storage: NLANE byte-wide arrays of RAM_SIZE/NLANE entries, indexed by word address HADDR[RAM_ADDR-1:LSB]. The arrays are never reset.
- Read: the array is read on the accepting edge of the address phase and the result is registered. S_HRDATA shows it only in the final data-phase cycle of a read; at all other times S_HRDATA = 0.
- Write: the masked lanes are written with S_HWDATA on the final data-phase edge, i.e. the edge where S_HREADYOUT = 1.
- Forwarding: a read address phase and a write commit can coincide on the same edge to the same word. In that case each lane written by the commit returns the new write byte; the other lanes return array data.
- State machine:
  - IDLE: no data phase.
  - WAIT: counting wait states.
  - ERR1, ERR2: ERROR response cycles.
- Transitions:
  - IDLE → WAIT on acceptance when WAIT_CYCLES > 0; otherwise it stays in a zero-wait data phase.
  - WAIT stays until count == WAIT_CYCLES.
  - An accepted illegal transfer (macro enabled) goes to ERR1 → ERR2.
  - The next transfer can be accepted on the last data-phase edge (pipelined).
- The 4-bit wait counter clears on acceptance and increments in WAIT. HREADYOUT = 1 when the count equals WAIT_CYCLES.
- IDLE/BUSY transfers and unselected cycles: no data phase, OKAY, S_HREADYOUT = 1.

## Timing
- Reset values (RES_N sampled low at an edge): state IDLE, S_HREADYOUT = 1, S_HRESP = 0, S_HRDATA = 0, wait counter 0, forwarding flags 0.
- Reset asserted mid-transfer aborts it; a pending write is discarded.
- Latency: a read completes WAIT_CYCLES+1 cycles after address acceptance. A write commits on the same edge.
- ERROR: a two-cycle response, independent of WAIT_CYCLES.
  - ERR1: HREADYOUT = 0, HRESP = 1.
  - ERR2: HREADYOUT = 1, HRESP = 1.
  - No array access takes place.
  - An address phase presented during ERR2 is accepted normally.
- Wait-state value 15 gives a 16-cycle data phase; the counter must not wrap.

## Configuration
- Macro AHB_RAM_GEN2_ERR_EN.
- Defined: oversize or misaligned transfers get the two-cycle ERROR response, with no read and no write.
- Undefined: S_HRESP is tied to 0. Oversize is treated as full width (all lanes), and misaligned addresses are truncated to size alignment.

## Test plan
- DATA_WIDTH=32, WAIT_CYCLES=0: write word 0x11223344 to 0x100, then read 0x100 back-to-back → read returns 0x11223344 via forwarding, with S_HREADYOUT held at 1.
- DATA_WIDTH=64: byte write 0xAB to 0x105 over prior data 0x0 → read of 0x100 returns 0x0000AB0000000000.
- WAIT_CYCLES=3: a read shows S_HREADYOUT low for 3 cycles, and data appears only in the 4th cycle; S_HRDATA = 0 before that.
- Macro defined: halfword write at 0x101 → ERR1/ERR2 sequence (HREADYOUT 0 then 1, HRESP 1 for both cycles), and the memory is unchanged on readback.
- Macro undefined: the same transfer gives an OKAY response and writes lanes 0–1.
- RES_N pulled low during the 2nd wait cycle of a write → outputs show reset values next cycle, and the target word is unchanged on readback.
